// File: rtl/fir_loader_if.sv
// Control/data bundle between a FIR loader and whoever feeds it buffer writes and start requests.
// The master side writes buffers and starts sequences; the slave side is the loader itself.
interface fir_loader_if #(
   parameter int TAPS = 16,
   parameter int W    = 16
);
   localparam int AW = $clog2(TAPS);

   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          start;
   logic [7:0]    run_len;
   logic          abort;
   logic          busy;
   logic          done;
   logic          wr_err;
   logic          wind;
   logic          load;
   logic          in_valid;
   logic [W-1:0]  data;

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, run_len, abort,
      input  busy, done, wr_err, wind, load, in_valid, data
   );

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, run_len, abort,
      output busy, done, wr_err, wind, load, in_valid, data
   );
endinterface

// File: rtl/fir_loader.sv
// Sequences coefficient wind-in, sample load and run strobes into a FIR from two local buffers.
// Optional macro FIR_LOADER_COEF_SKIP_EN skips the wind phase when coefficients are unchanged.
module fir_loader #(
   parameter int TAPS = 16,
   parameter int W    = 16
) (
   input  logic          clk,
   input  logic          rstb,
   fir_loader_if.slave   bus
);
   localparam int AW = $clog2(TAPS);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {IDLE, WIND, LOAD, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [7:0]    run_cnt_q, run_cnt_d;
   logic [7:0]    run_len_q, run_len_d;
   logic [W-1:0]  coef_q [TAPS];
   logic [W-1:0]  coef_d [TAPS];
   logic [W-1:0]  samp_q [TAPS];
   logic [W-1:0]  samp_d [TAPS];

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          wr_err_q, wr_err_d;
   logic          wind_q, wind_d;
   logic          load_q, load_d;
   logic          in_valid_q, in_valid_d;
   logic [W-1:0]  data_q, data_d;

`ifdef FIR_LOADER_COEF_SKIP_EN
   logic          coef_dirty_q, coef_dirty_d;
`endif

   logic          last_phase;
   logic          wr_ok;

   assign last_phase = (phase_q == PW'(TAPS - 1));
   assign wr_ok      = bus.wr_en && (state_q == IDLE) && !bus.start;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         run_cnt_q  <= '0;
         run_len_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_err_q   <= 1'b0;
         wind_q     <= 1'b0;
         load_q     <= 1'b0;
         in_valid_q <= 1'b0;
         data_q     <= '0;
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
            samp_q[i] <= '0;
         end
`ifdef FIR_LOADER_COEF_SKIP_EN
         coef_dirty_q <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         run_cnt_q  <= run_cnt_d;
         run_len_q  <= run_len_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_err_q   <= wr_err_d;
         wind_q     <= wind_d;
         load_q     <= load_d;
         in_valid_q <= in_valid_d;
         data_q     <= data_d;
         coef_q     <= coef_d;
         samp_q     <= samp_d;
`ifdef FIR_LOADER_COEF_SKIP_EN
         coef_dirty_q <= coef_dirty_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      run_cnt_d = run_cnt_q;
      run_len_d = run_len_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               run_len_d = bus.run_len;
               phase_d   = '0;
               run_cnt_d = '0;
               state_d   = WIND;
`ifdef FIR_LOADER_COEF_SKIP_EN
               if (!coef_dirty_q) state_d = LOAD;
`endif
            end
         end
         WIND: begin
            if (bus.abort) begin
               state_d = IDLE;
               phase_d = '0;
            end else if (last_phase) begin
               state_d = LOAD;
               phase_d = '0;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         LOAD: begin
            if (bus.abort) begin
               state_d = IDLE;
               phase_d = '0;
            end else if (last_phase) begin
               phase_d   = '0;
               run_cnt_d = '0;
               state_d   = (run_len_q == 8'd0) ? DONE : RUN;
            end else begin
               phase_d = phase_q + PW'(1);
            end
         end
         RUN: begin
            // run_len_q is nonzero here, so the subtraction never wraps
            if (bus.abort) begin
               state_d = IDLE;
            end else if (run_cnt_q == run_len_q - 8'd1) begin
               state_d = DONE;
            end else begin
               run_cnt_d = run_cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered strobes line up with the state they describe
   always_comb begin
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      wind_d     = (state_d == WIND);
      load_d     = (state_d == LOAD);
      in_valid_d = (state_d == RUN);
      wr_err_d   = bus.wr_en && ((state_q != IDLE) || bus.start);
      case (state_d)
         WIND:    data_d = coef_q[phase_d[AW-1:0]];
         LOAD:    data_d = samp_q[phase_d[AW-1:0]];
         RUN:     data_d = samp_q[TAPS-1];
         default: data_d = '0;
      endcase
   end

   always_comb begin
      coef_d = coef_q;
      samp_d = samp_q;
      if (wr_ok) begin
         if (bus.wr_sel) samp_d[bus.wr_addr] = bus.wr_data;
         else            coef_d[bus.wr_addr] = bus.wr_data;
      end
   end

`ifdef FIR_LOADER_COEF_SKIP_EN
   always_comb begin
      coef_dirty_d = coef_dirty_q;
      if (wr_ok && !bus.wr_sel) coef_dirty_d = 1'b1;
      if ((state_q == WIND) && !bus.abort && last_phase) coef_dirty_d = 1'b0;
   end
`endif

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.wr_err   = wr_err_q;
   assign bus.wind     = wind_q;
   assign bus.load     = load_q;
   assign bus.in_valid = in_valid_q;
   assign bus.data     = data_q;
endmodule

// File: doc/fir_loader.md
FIR_LOADER -- requirements
Module: fir_loader

Interface
REQ-001 The module SHALL have parameter TAPS, default 16, meaning the number of FIR taps; it is a power of two, at least 2.
REQ-002 The module SHALL have parameter W, default 16, meaning the sample and coefficient width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rstb, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port wr_en, input, 1 bit: buffer write strobe.
REQ-006 The module SHALL have port wr_sel, input, 1 bit: write target, 0 = coefficient buffer, 1 = sample buffer.
REQ-007 The module SHALL have port wr_addr, input, log2(TAPS) bits: buffer entry index.
REQ-008 The module SHALL have port wr_data, input, W bits: write value.
REQ-009 The module SHALL have port start, input, 1 bit: begin a sequence.
REQ-010 The module SHALL have port run_len, input, 8 bits: number of in_valid cycles, sampled with start.
REQ-011 The module SHALL have port abort, input, 1 bit: cancel the active sequence.
REQ-012 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The module SHALL have port wr_err, output, 1 bit: one-cycle pulse for a rejected write.
REQ-015 The module SHALL have ports wind, load, in_valid (output, 1 bit each) and data (output, W bits); these drive the FIR's ports of the same names.

Function
REQ-016 The module SHALL use an FSM with states IDLE, WIND, LOAD, RUN and DONE.
REQ-017 All outputs SHALL be registered.
REQ-018 In IDLE, a write with wr_en=1 and start=0 SHALL store wr_data at coef[wr_addr] or samp[wr_addr] at that clock edge.
REQ-019 A write asserted while busy=1, or in the same cycle as an accepted start, SHALL be discarded, and wr_err SHALL be 1 in the following cycle.
REQ-020 If start=1 in IDLE at edge t, the FSM SHALL enter WIND, and run_len SHALL be latched at edge t.
REQ-021 If start=1 when the FSM is not in IDLE, start SHALL be ignored.
REQ-022 WIND SHALL last exactly TAPS cycles, with wind=1 and data=coef[0..TAPS-1] in index order; the first such cycle is the one after edge t.
REQ-023 LOAD SHALL immediately follow WIND and last exactly TAPS cycles, with load=1 and data=samp[0..TAPS-1] in order.
REQ-024 RUN SHALL follow LOAD and last exactly the latched run_len cycles, with in_valid=1 and data holding samp[TAPS-1].
REQ-025 If the latched run_len is 0, the FSM SHALL go from LOAD directly to DONE.
REQ-026 In DONE (exactly 1 cycle), done=1, wind=load=in_valid=0 and busy=1; the FSM SHALL then return to IDLE.
REQ-027 At most one of wind, load and in_valid SHALL be 1 in any cycle.
REQ-028 In IDLE and DONE, data SHALL be 0.
REQ-029 abort=1 in WIND, LOAD or RUN SHALL force IDLE on the next cycle, with all strobes and data at 0 and no done pulse.
REQ-030 abort SHALL have no effect in IDLE or DONE.
REQ-031 If abort and start are both high in IDLE, start SHALL win.
REQ-032 The phase counter SHALL be log2(TAPS)+1 bits and the run counter 8 bits; the module SHALL NOT depend on wrap-around.
REQ-033 A sequence of TAPS coefficients, TAPS samples and run_len=N SHALL occupy exactly 2*TAPS+N+1 busy cycles.

Reset
REQ-034 While rstb=0 at a rising clk edge, the module SHALL enter IDLE.
REQ-035 During that reset, busy, done, wr_err, wind, load, in_valid and data SHALL all become 0.
REQ-036 During that reset, all coef and samp entries and the counters SHALL be cleared to 0.
REQ-037 Reset SHALL take priority over start, abort and wr_en.
REQ-038 Reset asserted mid-sequence SHALL terminate the sequence without a done pulse.

Configuration
REQ-039 With macro FIR_LOADER_COEF_SKIP_EN defined, a coef_dirty flag SHALL be set by reset and by any accepted coefficient write.
REQ-040 With FIR_LOADER_COEF_SKIP_EN defined, coef_dirty SHALL be cleared on completion of WIND.
REQ-041 With FIR_LOADER_COEF_SKIP_EN defined, a start with coef_dirty=0 SHALL enter LOAD directly; that sequence lasts TAPS+N+1 busy cycles.
REQ-042 With FIR_LOADER_COEF_SKIP_EN undefined, every sequence SHALL include WIND, and no coef_dirty flag SHALL exist.

Verification
REQ-043 Load coef[i]=1 and samp[i]=i+1 (i=0..15), then start with run_len=6 -> expect 16 cycles of wind=1 and data=1; then 16 cycles of load=1 and data=1..16; then 6 cycles of in_valid=1 and data=16; then done=1 for 1 cycle; busy high for 39 cycles.
REQ-044 start with run_len=0 -> expect load directly followed by done, and in_valid never 1.
REQ-045 abort in the 5th LOAD cycle -> expect IDLE and all strobes 0 on the next cycle, with done never asserted.
REQ-046 wr_en during WIND, and wr_en in the same cycle as start -> expect a wr_err pulse the following cycle for each, and buffer contents unchanged (verified on the next sequence).
REQ-047 rstb=0 for 1 cycle during RUN -> expect all outputs 0 and the buffers reading 0 on the next sequence.
REQ-048 With FIR_LOADER_COEF_SKIP_EN defined, run two back-to-back starts with no coefficient write between them -> expect the second sequence to have no wind cycles and a busy length of TAPS+N+1.
